// File: rtl/prco_mem_ctrl.sv
// -----------------------------------------------------------------------------
// prco_mem_ctrl
//
// Initiator side of the core's local memory port. Arbitrates between the fetch
// stage and the load/store stage (load/store has priority), issues a one-cycle
// class-specific strobe (q_mem_ce_fetch or q_mem_ce_alu) with address, write
// enable and write data, then waits for the matching response pulse and returns
// the captured word to the requester.
//
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_fetch_req/i_fetch_pc  fetch request (held until q_fetch_ack)
//   q_fetch_ack             one-cycle accept pulse for fetch
//   q_instr/q_instr_valid   fetched word and its one-cycle valid pulse
//   i_ls_req/we/addr/wdata  load/store request (held until q_ls_ack)
//   q_ls_ack                one-cycle accept pulse for load/store
//   q_ls_rdata/q_ls_done    read word (pre-write contents on a store) + done
//   q_mem_ce_fetch/alu      memory strobes, fetch-class / data-class
//   q_mem_we/addr/dina      write enable (data class only), address, data
//   i_mem_ce_dec/ce_reg     memory response pulses, fetch / data class
//   i_mem_douta             memory read data, valid in the response cycle
//   q_busy                  high whenever the FSM is not IDLE
//   q_timeout, q_range_err  sticky error flags, cleared only by reset
//
// Timing: request accepted in IDLE at N, strobe at N+1, response expected at
// N+2, completion pulse at N+3 (which is an IDLE cycle, so the next request
// can be accepted in that same cycle).
// -----------------------------------------------------------------------------
module prco_mem_ctrl #(
   parameter int unsigned P_LMEM_DEPTH = 255,
   parameter int unsigned P_TIMEOUT    = 15
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_fetch_req,
   input  logic [15:0] i_fetch_pc,
   output logic        q_fetch_ack,
   output logic [15:0] q_instr,
   output logic        q_instr_valid,
   input  logic        i_ls_req,
   input  logic        i_ls_we,
   input  logic [15:0] i_ls_addr,
   input  logic [15:0] i_ls_wdata,
   output logic        q_ls_ack,
   output logic [15:0] q_ls_rdata,
   output logic        q_ls_done,
   output logic        q_mem_ce_fetch,
   output logic        q_mem_ce_alu,
   output logic        q_mem_we,
   output logic [15:0] q_mem_addr,
   output logic [15:0] q_mem_dina,
   input  logic        i_mem_ce_dec,
   input  logic        i_mem_ce_reg,
   input  logic [15:0] i_mem_douta,
   output logic        q_busy,
   output logic        q_timeout,
   output logic        q_range_err
);

   // The counter holds the number of unmatched WAIT cycles already spent, so
   // the abort fires on the P_TIMEOUT-th unmatched cycle when it equals
   // P_TIMEOUT-1; it never needs to represent P_TIMEOUT itself.
   localparam int               CNT_W    = (P_TIMEOUT > 1) ? $clog2(P_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P_TIMEOUT - 1);
   localparam logic [15:0]      ADDR_MAX = 16'(P_LMEM_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_ERR  = 2'd3
   } state_t;

   state_t           state_q,       state_d;
   logic             cls_alu_q,     cls_alu_d;     // 1 = data class, 0 = fetch
   logic [15:0]      addr_q,        addr_d;
   logic [15:0]      dina_q,        dina_d;
   logic             we_q,          we_d;
   logic [CNT_W-1:0] cnt_q,         cnt_d;
   logic             ce_fetch_q,    ce_fetch_d;
   logic             ce_alu_q,      ce_alu_d;
   logic             mem_we_q,      mem_we_d;
   logic [15:0]      instr_q,       instr_d;
   logic             instr_valid_q, instr_valid_d;
   logic [15:0]      ls_rdata_q,    ls_rdata_d;
   logic             ls_done_q,     ls_done_d;
   logic             busy_q,        busy_d;
   logic             timeout_q,     timeout_d;
   logic             range_err_q,   range_err_d;

   logic             fetch_ack;
   logic             ls_ack;
   logic             accept;
   logic             acc_alu;
   logic             acc_we;
   logic [15:0]      acc_addr;
   logic [15:0]      acc_dina;
   logic             match;
   logic             cmpl;
   logic [15:0]      cmpl_data;

   always_comb begin
      state_d       = state_q;
      cls_alu_d     = cls_alu_q;
      addr_d        = addr_q;
      dina_d        = dina_q;
      we_d          = we_q;
      cnt_d         = cnt_q;
      ce_fetch_d    = 1'b0;
      ce_alu_d      = 1'b0;
      mem_we_d      = 1'b0;
      instr_d       = instr_q;
      instr_valid_d = 1'b0;
      ls_rdata_d    = ls_rdata_q;
      ls_done_d     = 1'b0;
      timeout_d     = timeout_q;
      range_err_d   = range_err_q;
      fetch_ack     = 1'b0;
      ls_ack        = 1'b0;
      accept        = 1'b0;
      acc_alu       = 1'b0;
      acc_we        = 1'b0;
      acc_addr      = 16'h0000;
      acc_dina      = 16'h0000;
      match         = 1'b0;
      cmpl          = 1'b0;
      cmpl_data     = 16'h0000;

      case (state_q)
         S_IDLE: begin
            // Load/store has priority; a pending fetch simply stays requested
            // and is picked up in a later IDLE cycle.
            if (i_ls_req) begin
               ls_ack   = 1'b1;
               accept   = 1'b1;
               acc_alu  = 1'b1;
               acc_we   = i_ls_we;
               acc_addr = i_ls_addr;
               acc_dina = i_ls_wdata;
            end else if (i_fetch_req) begin
               fetch_ack = 1'b1;
               accept    = 1'b1;
               acc_addr  = i_fetch_pc;
            end
            if (accept) begin
               cls_alu_d = acc_alu;
               we_d      = acc_we;
               addr_d    = acc_addr;
               dina_d    = acc_dina;
               if (acc_addr > ADDR_MAX) begin
                  state_d = S_ERR;
               end else begin
                  // Strobes are registered so they appear exactly in REQ.
                  state_d    = S_REQ;
                  ce_fetch_d = ~acc_alu;
                  ce_alu_d   = acc_alu;
                  mem_we_d   = acc_alu & acc_we;
               end
            end
         end
         S_REQ: begin
            state_d = S_WAIT;
            cnt_d   = '0;
         end
         S_WAIT: begin
            // Only the response of our own class counts; the other is noise.
            match = cls_alu_q ? i_mem_ce_reg : i_mem_ce_dec;
            if (match) begin
               cmpl      = 1'b1;
               cmpl_data = i_mem_douta;
               state_d   = S_IDLE;
            end else if (cnt_q == CNT_LAST) begin
               cmpl      = 1'b1;
               timeout_d = 1'b1;
               state_d   = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_ERR: begin
            cmpl        = 1'b1;
            range_err_d = 1'b1;
            state_d     = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (cmpl) begin
         if (cls_alu_q) begin
            ls_rdata_d = cmpl_data;
            ls_done_d  = 1'b1;
         end else begin
            instr_d       = cmpl_data;
            instr_valid_d = 1'b1;
         end
      end

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q       <= S_IDLE;
         cls_alu_q     <= 1'b0;
         addr_q        <= 16'h0000;
         dina_q        <= 16'h0000;
         we_q          <= 1'b0;
         cnt_q         <= '0;
         ce_fetch_q    <= 1'b0;
         ce_alu_q      <= 1'b0;
         mem_we_q      <= 1'b0;
         instr_q       <= 16'h0000;
         instr_valid_q <= 1'b0;
         ls_rdata_q    <= 16'h0000;
         ls_done_q     <= 1'b0;
         busy_q        <= 1'b0;
         timeout_q     <= 1'b0;
         range_err_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         cls_alu_q     <= cls_alu_d;
         addr_q        <= addr_d;
         dina_q        <= dina_d;
         we_q          <= we_d;
         cnt_q         <= cnt_d;
         ce_fetch_q    <= ce_fetch_d;
         ce_alu_q      <= ce_alu_d;
         mem_we_q      <= mem_we_d;
         instr_q       <= instr_d;
         instr_valid_q <= instr_valid_d;
         ls_rdata_q    <= ls_rdata_d;
         ls_done_q     <= ls_done_d;
         busy_q        <= busy_d;
         timeout_q     <= timeout_d;
         range_err_q   <= range_err_d;
      end
   end

   // Acks must land in the accept cycle itself, so they decode the state.
   assign q_fetch_ack    = fetch_ack;
   assign q_ls_ack       = ls_ack;
   assign q_instr        = instr_q;
   assign q_instr_valid  = instr_valid_q;
   assign q_ls_rdata     = ls_rdata_q;
   assign q_ls_done      = ls_done_q;
   assign q_mem_ce_fetch = ce_fetch_q;
   assign q_mem_ce_alu   = ce_alu_q;
   assign q_mem_we       = mem_we_q;
   assign q_mem_addr     = addr_q;
   assign q_mem_dina     = dina_q;
   assign q_busy         = busy_q;
   assign q_timeout      = timeout_q;
   assign q_range_err    = range_err_q;

endmodule

// File: tb/tb_prco_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_prco_mem_ctrl
//
// Directed bench for prco_mem_ctrl. A small behavioural memory answers strobes
// with a configurable delay (or not at all) and can inject a stray data-class
// response; the main sequence walks fetch, store/load, arbitration, timeout,
// range error, reset-in-WAIT and stray-response cases against hand-computed
// values and latencies.
// -----------------------------------------------------------------------------
module tb_prco_mem_ctrl;

   logic        clk;
   logic        i_reset;
   logic        i_fetch_req;
   logic [15:0] i_fetch_pc;
   logic        q_fetch_ack;
   logic [15:0] q_instr;
   logic        q_instr_valid;
   logic        i_ls_req;
   logic        i_ls_we;
   logic [15:0] i_ls_addr;
   logic [15:0] i_ls_wdata;
   logic        q_ls_ack;
   logic [15:0] q_ls_rdata;
   logic        q_ls_done;
   logic        q_mem_ce_fetch;
   logic        q_mem_ce_alu;
   logic        q_mem_we;
   logic [15:0] q_mem_addr;
   logic [15:0] q_mem_dina;
   logic        i_mem_ce_dec;
   logic        i_mem_ce_reg;
   logic [15:0] i_mem_douta;
   logic        q_busy;
   logic        q_timeout;
   logic        q_range_err;

   int checks   = 0;
   int failures = 0;

   // Responder controls (written by the main sequence only).
   logic resp_en    = 1'b1;
   int   resp_delay = 0;
   logic spur_en    = 1'b0;

   prco_mem_ctrl #(.P_LMEM_DEPTH(255), .P_TIMEOUT(15)) dut (
      .i_clk          (clk),
      .i_reset        (i_reset),
      .i_fetch_req    (i_fetch_req),
      .i_fetch_pc     (i_fetch_pc),
      .q_fetch_ack    (q_fetch_ack),
      .q_instr        (q_instr),
      .q_instr_valid  (q_instr_valid),
      .i_ls_req       (i_ls_req),
      .i_ls_we        (i_ls_we),
      .i_ls_addr      (i_ls_addr),
      .i_ls_wdata     (i_ls_wdata),
      .q_ls_ack       (q_ls_ack),
      .q_ls_rdata     (q_ls_rdata),
      .q_ls_done      (q_ls_done),
      .q_mem_ce_fetch (q_mem_ce_fetch),
      .q_mem_ce_alu   (q_mem_ce_alu),
      .q_mem_we       (q_mem_we),
      .q_mem_addr     (q_mem_addr),
      .q_mem_dina     (q_mem_dina),
      .i_mem_ce_dec   (i_mem_ce_dec),
      .i_mem_ce_reg   (i_mem_ce_reg),
      .i_mem_douta    (i_mem_douta),
      .q_busy         (q_busy),
      .q_timeout      (q_timeout),
      .q_range_err    (q_range_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Behavioural memory: sees a strobe in the strobe cycle (negedge), answers
   // in the following cycle plus resp_delay extra cycles. Reads return the
   // pre-write contents.
   logic [15:0] mem [0:255];
   initial begin
      logic        pend;
      logic        pend_fetch;
      logic [15:0] pend_data;
      int          pend_cnt;
      logic        spur_next;
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      mem[8'h01] = 16'h23CD;
      mem[8'h05] = 16'h1234;
      mem[8'hAA] = 16'h00CA;
      mem[8'hCD] = 16'h5555;
      pend         = 1'b0;
      pend_fetch   = 1'b0;
      pend_data    = 16'h0000;
      pend_cnt     = 0;
      spur_next    = 1'b0;
      i_mem_ce_dec = 1'b0;
      i_mem_ce_reg = 1'b0;
      i_mem_douta  = 16'h0000;
      forever begin
         @(negedge clk);
         i_mem_ce_dec = 1'b0;
         i_mem_ce_reg = 1'b0;
         i_mem_douta  = 16'h0000;
         if (spur_next) begin
            i_mem_ce_reg = 1'b1;
            i_mem_douta  = 16'hDEAD;
            spur_next    = 1'b0;
         end
         if (pend) begin
            if (pend_cnt == 0) begin
               i_mem_ce_dec = pend_fetch;
               i_mem_ce_reg = ~pend_fetch;
               i_mem_douta  = pend_data;
               pend         = 1'b0;
            end else begin
               pend_cnt--;
            end
         end
         if (resp_en && (q_mem_ce_fetch || q_mem_ce_alu)) begin
            pend       = 1'b1;
            pend_fetch = q_mem_ce_fetch;
            pend_cnt   = resp_delay;
            pend_data  = mem[q_mem_addr[7:0]];
            if (q_mem_ce_alu && q_mem_we) mem[q_mem_addr[7:0]] = q_mem_dina;
            if (spur_en && q_mem_ce_fetch) spur_next = 1'b1;
         end
      end
   end

   task automatic check_all_zero(input string tag);
      check_val({tag, ".outs_a"},
                {q_fetch_ack, q_instr, q_instr_valid, q_ls_ack, q_ls_rdata, q_ls_done}, 64'h0);
      check_val({tag, ".outs_b"},
                {q_mem_ce_fetch, q_mem_ce_alu, q_mem_we, q_mem_addr, q_mem_dina,
                 q_busy, q_timeout, q_range_err}, 64'h0);
   endtask

   // Drives one request in the current (IDLE) cycle, then follows it to its
   // completion pulse, checking ack, strobe cycle, latency and returned data.
   task automatic xact(input string tag, input logic is_ls, input logic we,
                       input logic [15:0] addr, input logic [15:0] wdata,
                       input logic [15:0] exp_data, input int exp_lat,
                       input logic exp_strobe);
      int   cyc;
      logic seen;
      if (is_ls) begin
         i_ls_req = 1'b1; i_ls_we = we; i_ls_addr = addr; i_ls_wdata = wdata;
      end else begin
         i_fetch_req = 1'b1; i_fetch_pc = addr;
      end
      #1;
      check_val({tag, ".ack"}, is_ls ? q_ls_ack : q_fetch_ack, 64'h1);
      check_val({tag, ".ack_other"}, is_ls ? q_fetch_ack : q_ls_ack, 64'h0);
      seen = 1'b0;
      cyc  = 0;
      while (!seen && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         if (cyc == 1) begin
            if (is_ls) i_ls_req = 1'b0; else i_fetch_req = 1'b0;
            if (exp_strobe) begin
               check_val({tag, ".strobe"}, {q_mem_ce_fetch, q_mem_ce_alu, q_mem_we},
                         {61'h0, ~is_ls, is_ls, is_ls & we});
               check_val({tag, ".mem_addr"}, q_mem_addr, addr);
               if (is_ls && we) check_val({tag, ".mem_dina"}, q_mem_dina, wdata);
            end else begin
               check_val({tag, ".no_strobe"}, {q_mem_ce_fetch, q_mem_ce_alu}, 64'h0);
            end
         end
         if (!is_ls) check_val({tag, ".no_alu"}, {q_mem_ce_alu, q_mem_we}, 64'h0);
         seen = is_ls ? q_ls_done : q_instr_valid;
      end
      check_val({tag, ".latency"}, 64'(cyc), 64'(exp_lat));
      check_val({tag, ".data"}, is_ls ? q_ls_rdata : q_instr, exp_data);
      $display("xact %s addr=0x%04h latency=%0d data=0x%04h", tag, addr, cyc,
               is_ls ? q_ls_rdata : q_instr);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      logic seen;
      i_reset     = 1'b1;
      i_fetch_req = 1'b0;
      i_fetch_pc  = 16'h0000;
      i_ls_req    = 1'b0;
      i_ls_we     = 1'b0;
      i_ls_addr   = 16'h0000;
      i_ls_wdata  = 16'h0000;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      i_reset = 1'b0;
      @(posedge clk); #1;
      check_all_zero("idle");

      // Plain fetch, then store and read-back.
      xact("fetch1", 1'b0, 1'b0, 16'h0001, 16'h0000, 16'h23CD, 3, 1'b1);
      xact("store",  1'b1, 1'b1, 16'h00CD, 16'h00AB, 16'h5555, 3, 1'b1);
      xact("load",   1'b1, 1'b0, 16'h00CD, 16'h0000, 16'h00AB, 3, 1'b1);

      // Simultaneous requests: load wins, fetch waits for the done cycle.
      i_ls_req = 1'b1; i_ls_we = 1'b0; i_ls_addr = 16'h00AA;
      i_fetch_req = 1'b1; i_fetch_pc = 16'h0005;
      #1;
      check_val("sim.ls_ack", q_ls_ack, 64'h1);
      check_val("sim.fetch_ack_held", q_fetch_ack, 64'h0);
      seen = 1'b0;
      cyc  = 0;
      while (!seen && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         if (cyc == 1) i_ls_req = 1'b0;
         seen = q_ls_done;
         if (!seen) check_val("sim.fetch_ack_early", q_fetch_ack, 64'h0);
      end
      check_val("sim.ls_latency", 64'(cyc), 64'd3);
      check_val("sim.ls_rdata", q_ls_rdata, 64'h00CA);
      $display("xact sim_load addr=0x00aa latency=%0d data=0x%04h", cyc, q_ls_rdata);
      xact("sim_fetch", 1'b0, 1'b0, 16'h0005, 16'h0000, 16'h1234, 3, 1'b1);

      // Fetch with no memory response: aborts after 15 WAIT cycles.
      check_val("tmo.flag_before", q_timeout, 64'h0);
      resp_en = 1'b0;
      xact("tmo", 1'b0, 1'b0, 16'h0002, 16'h0000, 16'h0000, 17, 1'b1);
      resp_en = 1'b1;
      check_val("tmo.flag", q_timeout, 64'h1);
      xact("after_tmo", 1'b0, 1'b0, 16'h0001, 16'h0000, 16'h23CD, 3, 1'b1);
      check_val("tmo.sticky", q_timeout, 64'h1);

      // Out-of-range load: no strobe, done two cycles after ack.
      check_val("rng.flag_before", q_range_err, 64'h0);
      xact("rng", 1'b1, 1'b0, 16'h0100, 16'h0000, 16'h0000, 2, 1'b0);
      check_val("rng.flag", q_range_err, 64'h1);

      // Reset while in WAIT; the late response must be ignored.
      resp_delay = 1;
      i_ls_req = 1'b1; i_ls_we = 1'b0; i_ls_addr = 16'h0001;
      @(posedge clk); #1;
      i_ls_req = 1'b0;
      @(posedge clk); #1;
      check_val("rst.in_wait_busy", q_busy, 64'h1);
      i_reset = 1'b1;
      @(posedge clk); #1;
      i_reset = 1'b0;
      check_all_zero("rst.n3");
      @(posedge clk); #1;
      check_all_zero("rst.n4");
      @(posedge clk); #1;
      check_all_zero("rst.n5");
      $display("xact reset_in_wait outputs cleared");
      resp_delay = 0;

      // Stray data-class response during a fetch WAIT is ignored.
      resp_delay = 2;
      spur_en    = 1'b1;
      xact("spur", 1'b0, 1'b0, 16'h0005, 16'h0000, 16'h1234, 5, 1'b1);
      spur_en    = 1'b0;
      resp_delay = 0;

      @(posedge clk); #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/prco_mem_ctrl.md
Name: prco_mem_ctrl

Overview:
Initiator side of the on-chip local memory port. It arbitrates between the fetch stage and the load/store (ALU) stage and issues single-cycle `ce_fetch`/`ce_alu` strobes with address, write enable and write data. It waits for the memory's `ce_dec`/`ce_reg` response pulse and returns the captured read word to the requester. It sits between the core pipeline and the local memory; all memory traffic from the core passes through it.

Parameters:
- P_LMEM_DEPTH, 255: highest valid word address; requests above it are not issued to memory.
- P_TIMEOUT, 15: cycles spent in WAIT without a matching response before the access is aborted.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_fetch_req  in  1  fetch request; held with i_fetch_pc until q_fetch_ack
- i_fetch_pc  in  16  instruction address
- q_fetch_ack  out  1  one-cycle pulse: fetch request accepted
- q_instr  out  16  fetched instruction word
- q_instr_valid  out  1  one-cycle pulse: q_instr valid
- i_ls_req  in  1  load/store request; held with operands until q_ls_ack
- i_ls_we  in  1  1 = store, 0 = load
- i_ls_addr  in  16  data address
- i_ls_wdata  in  16  store data
- q_ls_ack  out  1  one-cycle pulse: load/store accepted
- q_ls_rdata  out  16  memory word read at i_ls_addr (pre-write contents on a store)
- q_ls_done  out  1  one-cycle pulse: load/store complete
- q_mem_ce_fetch  out  1  memory strobe, fetch-class access
- q_mem_ce_alu  out  1  memory strobe, data-class access
- q_mem_we  out  1  memory write enable, qualified by q_mem_ce_alu
- q_mem_addr  out  16  memory address
- q_mem_dina  out  16  memory write data
- i_mem_ce_dec  in  1  memory response pulse for a fetch-class access
- i_mem_ce_reg  in  1  memory response pulse for a data-class access
- i_mem_douta  in  16  memory read data, valid in the response cycle
- q_busy  out  1  high in any state other than IDLE
- q_timeout  out  1  sticky: a WAIT timed out
- q_range_err  out  1  sticky: an address exceeded P_LMEM_DEPTH

Behaviour:
- Reset state:
  - FSM returns to IDLE.
  - All outputs are 0, including q_instr, q_ls_rdata, q_mem_addr and q_mem_dina.
  - Sticky error flags and the timeout counter are cleared.
  - Reset mid-access abandons the access; a late memory response is ignored in IDLE.
- FSM states: IDLE, REQ, WAIT, ERR.
- IDLE:
  - If i_ls_req is high, pulse q_ls_ack. Latch i_ls_we, i_ls_addr and i_ls_wdata, and set the class to data.
  - Otherwise, if i_fetch_req is high, pulse q_fetch_ack. Latch i_fetch_pc, and set the class to fetch.
  - If both requests are high, load/store wins. Fetch stays pending and is accepted no earlier than the cycle the load/store's q_ls_done pulses.
  - If the latched address is greater than P_LMEM_DEPTH, go to ERR; otherwise go to REQ.
- REQ (exactly one cycle):
  - Drive q_mem_addr and q_mem_dina from the latches.
  - Assert exactly one of q_mem_ce_fetch or q_mem_ce_alu, according to the class.
  - Assert q_mem_we = latched we for the data class only; fetch always has we = 0.
  - Go to WAIT and clear the timeout counter.
  - All strobes are 0 in every other state.
- WAIT:
  - On a matching response (i_mem_ce_dec for fetch, i_mem_ce_reg for data), capture i_mem_douta into q_instr or q_ls_rdata. Pulse q_instr_valid or q_ls_done the next cycle. Go to IDLE.
  - A non-matching response pulse is ignored.
  - The counter increments each cycle without a match. When it reaches P_TIMEOUT, set q_timeout, complete with data 0x0000 plus the valid/done pulse, and go to IDLE.
- ERR (one cycle):
  - Set q_range_err and issue no memory strobe.
  - Complete with data 0x0000 plus the valid/done pulse, then go to IDLE.
- Latency:
  - Request seen in IDLE at cycle N; strobe at N+1; memory response at N+2; valid/done pulse at N+3.
  - The valid/done cycle is IDLE, so a new request can be acked in that same cycle. Sustained throughput is one access per 3 cycles.
- Stores return done like loads. q_ls_rdata carries the pre-write contents returned by memory.
- Address arithmetic is unsigned 16-bit; no wrap or offset is applied here.

Test Plan:
- Fetch, PC=0x0001, memory holds 0x23CD:
  - ack at N, q_mem_ce_fetch=1 and addr 0x0001 at N+1.
  - q_instr=0x23CD with q_instr_valid at N+3.
  - q_mem_ce_alu and q_mem_we stay 0 throughout.
- Store 0x00AB to 0x00CD, then load 0x00CD:
  - Store: q_mem_ce_alu=1 and q_mem_we=1 for one cycle, then q_ls_done.
  - Load: q_ls_rdata=0x00AB.
- Simultaneous requests, fetch 0x0005 and load 0x00AA (holding 0x00CA):
  - q_ls_ack first, and q_ls_rdata=0x00CA.
  - q_fetch_ack not before the q_ls_done cycle; the fetch then completes normally.
- Fetch where memory never responds, P_TIMEOUT=15:
  - q_timeout set after 15 WAIT cycles; q_instr_valid with 0x0000.
  - Next request still serviced; q_timeout stays 1 until reset.
- Load from 0x0100:
  - No strobe issued; q_range_err=1; q_ls_done with 0x0000 two cycles after ack.
- i_reset asserted in WAIT, memory responds the next cycle:
  - FSM in IDLE, no valid/done pulse, all outputs 0.
- Spurious i_mem_ce_reg during a fetch WAIT:
  - Ignored; the fetch completes on the later i_mem_ce_dec.
